floo_mcast_rsp_reduce: RTL



---
 rtl/floo_mcast_rsp_reduce.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/floo_mcast_rsp_reduce.sv
// Merges the unicast responses of one multicast into a single worst-case response, in issue order.
// Optional duplicate-source filtering is enabled by defining FLOO_MCAST_DUP_CHECK_EN.
module floo_mcast_rsp_reduce #(
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned CntWidth       = 3,
  parameter int unsigned NumSrc         = 8,
  localparam int unsigned SrcW          = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                exp_valid_i,
  output logic                exp_ready_o,
  input  logic [CntWidth-1:0] exp_cnt_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  logic [1:0]          rsp_resp_i,
  input  logic [SrcW-1:0]     rsp_src_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [1:0]          rsp_resp_o,
  output logic                busy_o,
  output logic                dup_err_o
);

  localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned OccW = $clog2(NumOutstanding + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

  logic [CntWidth-1:0] fifo_q [NumOutstanding];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]     occ_q;
  logic                full, empty, push, pop;
  logic [CntWidth-1:0] head;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          acc_q, acc_d;
  logic [1:0]          beat_resp;
  logic                dup_hit;

  assign full        = (occ_q == OccW'(NumOutstanding));
  assign empty       = (occ_q == '0);
  assign exp_ready_o = !full;
  assign push        = exp_valid_i && exp_ready_o;
  assign head        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      occ_q <= occ_q + OccW'(push) - OccW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= exp_cnt_i;
  end

  // EXOKAY carries no meaning for a merged multicast response, so it ranks as OKAY.
  assign beat_resp = (rsp_resp_i == 2'd1) ? 2'd0 : rsp_resp_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    pop         = 1'b0;
    rsp_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = head;
          acc_d   = 2'd0;
          state_d = (head == '0) ? SEND : COLLECT;
        end
      end
      COLLECT: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i && !dup_hit) begin
          if (beat_resp > acc_q) acc_d = beat_resp;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntWidth'(1)) state_d = SEND;
        end
      end
      SEND: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

`ifdef FLOO_MCAST_DUP_CHECK_EN
  logic [NumSrc-1:0] seen_q, seen_d;

  assign dup_hit   = seen_q[rsp_src_i];
  assign dup_err_o = (state_q == COLLECT) && rsp_valid_i && dup_hit;

  always_comb begin
    seen_d = seen_q;
    if (pop) seen_d = '0;
    else if ((state_q == COLLECT) && rsp_valid_i) seen_d[rsp_src_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) seen_q <= '0;
    else         seen_q <= seen_d;
  end
`else
  logic unused_src;

  assign unused_src = ^rsp_src_i;
  assign dup_hit    = 1'b0;
  assign dup_err_o  = 1'b0;
`endif

  assign rsp_resp_o = acc_q;
  assign busy_o     = !empty || (state_q != IDLE);

  a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_resp_o)));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full);

endmodule
